wb_deserializer: RTL and testbench

Wishbone slave that receives the serial stream produced by the serializer stage (serial bit plus enable) and rebuilds 27-bit packets of three 9-bit symbols, each symbol being a k flag plus 8 data bits. Completed packets go into a small receive FIFO, and the bus master reads them out together with status and error flags. It sits directly downstream of wb_serializer, on the receive side of the link, and gives loopback and link tests a bus-visible endpoint.

---
 rtl/WBDeserializer.sv | 37 +++
 rtl/deserializer_in.sv | 82 ++++++++
 rtl/wb_deserializer.sv | 176 +++++++++++++++++
 tb/tb_wb_deserializer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/WBDeserializer.sv
// Shared definitions for the Wishbone packet deserializer: register map,
// packet geometry, framer state encoding and STATUS/CTRL bit positions.
package WBDeserializer;

    // A packet is three 9-bit symbols (k flag + 8 data bits).
    localparam int SYM_BITS = 9;
    localparam int PKT_BITS = 3 * SYM_BITS;

    // Register map; NUM_REGS marks the first undecoded address.
    typedef enum logic [1:0] {
        ADR_DATA   = 2'd0,
        ADR_STATUS = 2'd1,
        ADR_CTRL   = 2'd2,
        NUM_REGS   = 2'd3
    } adr_e;

    localparam int ADDR_SIZE = $bits(adr_e);

    // Framer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } frm_state_e;

    // STATUS register bit positions.
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_FERR    = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    // CTRL register bit positions.
    localparam int CTRL_CLR   = 0;
    localparam int CTRL_FLUSH = 1;

endpackage

// File: rtl/deserializer_in.sv
// Serial framer: collects PKT_BITS bits (MSB first) while ena_i is high and
// emits a one-cycle pkt_valid_o with the packet; a drop of ena_i mid-packet
// discards the partial packet and pulses ferr_o.
module deserializer_in
    import WBDeserializer::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ser_i,
    input  logic                ena_i,
    output logic [PKT_BITS-1:0] data_o,
    output logic                pkt_valid_o,
    output logic                ferr_o
);

    localparam int CNT_W = $clog2(PKT_BITS + 1);

    frm_state_e          state;
    frm_state_e          state_nx;
    logic [PKT_BITS-1:0] shreg;
    logic [PKT_BITS-1:0] shreg_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                valid_nx;
    logic                ferr_nx;

    // State, shift register, bit counter and the two event pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            pkt_valid_o <= 1'b0;
            ferr_o      <= 1'b0;
        end else begin
            state       <= state_nx;
            shreg       <= shreg_nx;
            cnt         <= cnt_nx;
            pkt_valid_o <= valid_nx;
            ferr_o      <= ferr_nx;
        end
    end

    // Next-state logic: IDLE takes the first bit directly so that a packet
    // following a completed one on an unbroken ena_i has no gap.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ena_i) begin
                    shreg_nx = {shreg[PKT_BITS-2:0], ser_i};
                    cnt_nx   = CNT_W'(1);
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ena_i) begin
                    shreg_nx = {shreg[PKT_BITS-2:0], ser_i};
                    if (cnt == CNT_W'(PKT_BITS - 1)) begin
                        cnt_nx   = '0;
                        valid_nx = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    cnt_nx   = '0;
                    ferr_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
        endcase
    end

    // The register holds the completed packet during the pkt_valid_o cycle.
    assign data_o = shreg;

endmodule

// File: rtl/wb_deserializer.sv
// Wishbone slave endpoint for the serial link: framer, receive FIFO and a
// three-register bus interface (DATA pop, STATUS, CTRL clear/flush).
//
// Handshake: a request is accepted on a cycle with CYC_I & STB_I while no
// response is showing and the current strobe has not yet been answered; the
// single registered ACK_O or ERR_O follows one cycle later, and a master must
// drop STB_I (or CYC_I) before the next request is taken.
module wb_deserializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int PKT_BITS   = WBDeserializer::PKT_BITS
) (
    input  logic        CLK_I,
    input  logic        RST_NI,
    input  logic        ser_i,
    input  logic        ena_i,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O,
    output logic        irq_o
);

    import WBDeserializer::adr_e;
    import WBDeserializer::ADR_DATA;
    import WBDeserializer::ADR_STATUS;
    import WBDeserializer::ADR_CTRL;
    import WBDeserializer::ADDR_SIZE;
    import WBDeserializer::STAT_EMPTY;
    import WBDeserializer::STAT_FULL;
    import WBDeserializer::STAT_OVF;
    import WBDeserializer::STAT_FERR;
    import WBDeserializer::STAT_CNT_LSB;
    import WBDeserializer::STAT_CNT_W;
    import WBDeserializer::CTRL_CLR;
    import WBDeserializer::CTRL_FLUSH;

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Framer outputs
    logic [PKT_BITS-1:0] pkt;
    logic                pkt_valid;
    logic                ferr_evt;

    // FIFO storage and bookkeeping
    logic [PKT_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      cnt;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                drop;

    // Sticky flags
    logic                ferr;
    logic                ovf;

    // Bus decode
    adr_e                adr;
    logic                held;
    logic                accept;
    logic                ctrl_wr;
    logic                flush;
    logic                clr;
    logic                req_ok;
    logic [31:0]         rsp_dat;
    logic [31:0]         status;
    logic                unused;

    deserializer_in u_framer (
        .clk_i       (CLK_I),
        .rst_ni      (RST_NI),
        .ser_i       (ser_i),
        .ena_i       (ena_i),
        .data_o      (pkt),
        .pkt_valid_o (pkt_valid),
        .ferr_o      (ferr_evt)
    );

    assign adr     = adr_e'(ADR_I[ADDR_SIZE-1:0]);
    assign accept  = CYC_I & STB_I & ~ACK_O & ~ERR_O & ~held;
    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign pop     = accept & ~WE_I & (adr == ADR_DATA) & ~empty;
    assign ctrl_wr = accept & WE_I & (adr == ADR_CTRL);
    assign flush   = ctrl_wr & DAT_I[CTRL_FLUSH];
    assign clr     = ctrl_wr & DAT_I[CTRL_CLR];
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push    = pkt_valid & ~flush & (~full | pop);
    assign drop    = pkt_valid & ~flush & full & ~pop;
    assign irq_o   = ~empty;
    assign unused  = ^{ADR_I[31:ADDR_SIZE], DAT_I[31:2]};

    // Assemble the STATUS word from the flags and occupancy.
    always_comb begin
        status                               = '0;
        status[STAT_EMPTY]                   = empty;
        status[STAT_FULL]                    = full;
        status[STAT_OVF]                     = ovf;
        status[STAT_FERR]                    = ferr;
        status[STAT_CNT_LSB +: STAT_CNT_W]   = STAT_CNT_W'(cnt);
    end

    // Decide whether the addressed access is legal and what a read returns.
    always_comb begin
        req_ok  = 1'b0;
        rsp_dat = '0;
        case (adr)
            ADR_DATA: begin
                req_ok = ~WE_I & ~empty;
                if (~WE_I & ~empty) rsp_dat = {{(32-PKT_BITS){1'b0}}, mem[rd_ptr]};
            end
            ADR_STATUS: begin
                req_ok = ~WE_I;
                if (~WE_I) rsp_dat = status;
            end
            ADR_CTRL: req_ok = WE_I;
            default:  req_ok = 1'b0;
        endcase
    end

    // FIFO storage write; contents need no reset since cnt gates every read.
    always_ff @(posedge CLK_I) begin
        if (push) mem[wr_ptr] <= pkt;
    end

    // FIFO pointers and occupancy; a flush overrides any push on the same edge.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Sticky error flags; a new event wins over a clear on the same edge.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            ferr <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            ferr <= (ferr & ~clr) | ferr_evt;
            ovf  <= (ovf & ~clr) | drop;
        end
    end

    // Registered bus response; held remembers that the current strobe has
    // already been answered so a master holding STB_I gets a single response.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            DAT_O <= '0;
            held  <= 1'b0;
        end else begin
            ACK_O <= accept & req_ok;
            ERR_O <= accept & ~req_ok;
            DAT_O <= accept ? rsp_dat : '0;
            held  <= CYC_I & STB_I & (held | accept);
        end
    end

endmodule

// File: tb/tb_wb_deserializer.sv
// Bench for wb_deserializer: a queue-based model of the link endpoint checked
// every cycle, plus directed packets and bus accesses with literal results.
module tb_wb_deserializer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser = 1'b0;
    logic        ena = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    logic        irq;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    wb_deserializer #(.FIFO_DEPTH(DEPTH), .PKT_BITS(27)) dut (
        .CLK_I  (clk),
        .RST_NI (rst_n),
        .ser_i  (ser),
        .ena_i  (ena),
        .CYC_I  (cyc),
        .STB_I  (stb),
        .WE_I   (we),
        .ADR_I  (adr),
        .DAT_I  (wdat),
        .ACK_O  (ack),
        .ERR_O  (err),
        .DAT_O  (rdat),
        .irq_o  (irq)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [26:0] m_acc = '0;
    int          m_nb = 0;
    bit          m_pend_v = 1'b0;
    logic [26:0] m_pend_pkt = '0;
    bit          m_pend_ferr = 1'b0;
    logic [26:0] m_q[$];
    bit          m_ferr = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_ack = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_dat = '0;

    function automatic logic [31:0] m_status();
        logic [3:0] c;
        c = 4'(m_q.size());
        return {24'b0, c, m_ferr, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = '0; m_nb = 0; m_pend_v = 0; m_pend_ferr = 0;
            m_q.delete(); m_ferr = 0; m_ovf = 0; m_busy = 0;
            m_ack = 0; m_err = 0; m_dat = '0;
        end else begin : mdl
            bit          take;
            bit          ok;
            bit          pop;
            bit          flush;
            bit          clr;
            bit          drop;
            logic [31:0] d;
            logic [1:0]  a;
            a = adr[1:0];
            take = cyc && stb && !m_busy;
            ok = 0; d = '0;
            if (take) begin
                if (!we) begin
                    if (a == 2'd0 && m_q.size() > 0) begin ok = 1; d = {5'b0, m_q[0]}; end
                    else if (a == 2'd1) begin ok = 1; d = m_status(); end
                end else if (a == 2'd2) ok = 1;
            end
            pop   = take && !we && a == 2'd0 && m_q.size() > 0;
            flush = take && we && a == 2'd2 && wdat[1];
            clr   = take && we && a == 2'd2 && wdat[0];
            m_ack = take && ok;
            m_err = take && !ok;
            m_dat = d;
            if (!(cyc && stb)) m_busy = 0;
            else if (take) m_busy = 1;
            drop = 0;
            if (flush) m_q.delete();
            else begin
                if (pop) void'(m_q.pop_front());
                if (m_pend_v) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_pend_pkt);
                    else drop = 1;
                end
            end
            m_ferr = (m_ferr && !clr) || m_pend_ferr;
            m_ovf  = (m_ovf && !clr) || drop;
            m_pend_v = 0; m_pend_ferr = 0;
            if (ena) begin
                m_acc = {m_acc[25:0], ser};
                m_nb++;
                if (m_nb == 27) begin m_pend_v = 1; m_pend_pkt = m_acc; m_nb = 0; end
            end else if (m_nb != 0) begin
                m_pend_ferr = 1; m_nb = 0;
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_irq", {31'b0, irq}, {31'b0, m_q.size() != 0});
            check("cyc_ack", {31'b0, ack}, {31'b0, m_ack});
            check("cyc_err", {31'b0, err}, {31'b0, m_err});
            check("cyc_dat", rdat, m_dat);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pkt(input logic [26:0] p);
        for (int i = 26; i >= 0; i--) begin
            @(negedge clk); ena = 1'b1; ser = p[i];
        end
    endtask

    task automatic send_bits(input logic [26:0] p, input int nbits);
        for (int i = 26; i > 26 - nbits; i--) begin
            @(negedge clk); ena = 1'b1; ser = p[i];
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk); ena = 1'b0; ser = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input bit we_v, input logic [31:0] a, input logic [31:0] wd,
                       output bit ack_v, output bit err_v, output logic [31:0] dat_v);
        @(negedge clk); cyc = 1; stb = 1; we = we_v; adr = a; wdat = wd;
        ack_v = 0; err_v = 0; dat_v = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack || err) begin ack_v = ack; err_v = err; dat_v = rdat; break; end
        end
        if (!(ack_v || err_v)) begin
            n_cmp++; n_fail++;
            $display("FAIL bus_timeout: got no response expected ACK or ERR at %0t", $time);
        end
        cyc = 0; stb = 0; we = 0; wdat = '0;
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input bit e_ack, input logic [31:0] e_dat);
        bit a_v; bit e_v; logic [31:0] d_v;
        bus(1'b0, a, '0, a_v, e_v, d_v);
        check({name, "_ack"}, {31'b0, a_v}, {31'b0, e_ack});
        check({name, "_err"}, {31'b0, e_v}, {31'b0, !e_ack});
        check({name, "_dat"}, d_v, e_dat);
    endtask

    task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d, input bit e_ack);
        bit a_v; bit e_v; logic [31:0] d_v;
        bus(1'b1, a, d, a_v, e_v, d_v);
        check({name, "_ack"}, {31'b0, a_v}, {31'b0, e_ack});
        check({name, "_err"}, {31'b0, e_v}, {31'b0, !e_ack});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acks;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        do_read("rst_status", 32'd1, 1'b1, 32'h0000_0001);

        // single packet
        send_pkt(27'h5A5A5A5);
        idle(2);
        check("pkt1_irq", {31'b0, irq}, 32'd1);
        check("pkt1_model_cnt", m_q.size(), 32'd1);
        do_read("pkt1_data", 32'd0, 1'b1, 32'h05A5A5A5);
        do_read("pkt1_status", 32'd1, 1'b1, 32'h0000_0001);
        do_write("wr_data_ro", 32'd0, 32'h1, 1'b0);
        do_read("rd_ctrl_wo", 32'd2, 1'b0, 32'h0);

        // five back-to-back packets, overflow on the fifth
        send_pkt(27'h0000001);
        send_pkt(27'h7FFFFFF);
        send_pkt(27'h1234567);
        send_pkt(27'h2AAAAAA);
        send_pkt(27'h5555555);
        idle(3);
        check("ovf_model_cnt", m_q.size(), 32'd4);
        do_read("ovf_status", 32'd1, 1'b1, 32'h0000_0046);
        do_read("ovf_rd1", 32'd0, 1'b1, 32'h0000_0001);
        do_read("ovf_rd2", 32'd0, 1'b1, 32'h07FF_FFFF);
        do_read("ovf_rd3", 32'd0, 1'b1, 32'h0123_4567);
        do_read("ovf_rd4", 32'd0, 1'b1, 32'h02AA_AAAA);
        do_read("ovf_rd5_empty", 32'd0, 1'b0, 32'h0);
        do_read("ovf_status2", 32'd1, 1'b1, 32'h0000_0005);
        do_write("ovf_clear", 32'd2, 32'h1, 1'b1);
        do_read("ovf_status3", 32'd1, 1'b1, 32'h0000_0001);

        // framing error after 13 bits, then a good packet
        send_bits(27'h1555555, 13);
        idle(2);
        send_pkt(27'h1FF0000);
        idle(3);
        do_read("ferr_status", 32'd1, 1'b1, 32'h0000_0018);
        do_read("ferr_data", 32'd0, 1'b1, 32'h01FF_0000);
        do_write("ferr_clear", 32'd2, 32'h1, 1'b1);
        do_read("ferr_status2", 32'd1, 1'b1, 32'h0000_0001);

        // STB held for four cycles with two entries queued
        send_pkt(27'h0000ABC);
        send_pkt(27'h7000001);
        idle(3);
        @(negedge clk); cyc = 1; stb = 1; we = 0; adr = 32'd0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) acks++;
        end
        cyc = 0; stb = 0;
        check("hold_acks", acks, 32'd1);
        do_read("hold_status", 32'd1, 1'b1, 32'h0000_0010);

        // flush on the same edge as a push, with two entries queued
        send_pkt(27'h0F0F0F0);
        idle(3);
        check("flush_model_cnt", m_q.size(), 32'd2);
        send_pkt(27'h3C3C3C3);
        @(negedge clk); ena = 0; cyc = 1; stb = 1; we = 1; adr = 32'd2; wdat = 32'h2;
        @(negedge clk);
        check("flush_ack", {31'b0, ack}, 32'd1);
        cyc = 0; stb = 0; we = 0; wdat = '0;
        do_read("flush_status", 32'd1, 1'b1, 32'h0000_0001);
        do_read("bad_addr3", 32'd3, 1'b0, 32'h0);

        // asynchronous reset at bit 10 of a packet
        send_pkt(27'h0000003);
        idle(2);
        send_bits(27'h7FFFFFF, 10);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("areset_ack", {31'b0, ack}, 32'd0);
        check("areset_err", {31'b0, err}, 32'd0);
        check("areset_dat", rdat, 32'd0);
        check("areset_irq", {31'b0, irq}, 32'd0);
        ena = 0; ser = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_pkt(27'h0ABCDEF);
        idle(3);
        do_read("post_rst_data", 32'd0, 1'b1, 32'h00AB_CDEF);
        do_read("post_rst_status", 32'd1, 1'b1, 32'h0000_0001);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #1000000;
        n_cmp++; n_fail++;
        $display("FAIL watchdog: got timeout expected end of stimulus at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
